// File: rtl/serial_request_scheduler.sv
// Purpose : sole writer of the serial send FIFO; arbitrates response bytes (strict priority)
//           against per-console frame-request bytes (round-robin, one outstanding per console).
// Latency : input accepted in IDLE -> fifo_wr_en high after the next edge, captured on the 2nd edge.
// Backpressure: nothing is accepted while fifo_full; at most one FIFO write every 3 cycles.
//
// Optional feature: define REQ_TIMEOUT_EN to build per-console pending-lock timeout counters.
//
// Ports:
//   clk, rst_l                       clock, asynchronous active-low reset
//   resp_valid/resp_byte/resp_ready  response byte handshake (resp_ready = taken this edge)
//   request_frame[NC]                console i buffer has room (level)
//   frame_delivered[NC]              pulse: frame for console i written, releases lock i
//   clear_prebuffer                  pulse: re-arm prebuffer, drop all locks, RR pointer -> 0
//   fifo_full                        send FIFO full
//   fifo_wr_en/fifo_data             registered FIFO write port
//   pending[NC]                      per-console lock state
//   prebuffer_done                   set once every request_frame is low at the same time
//   timeout_err                      pulse when any lock times out (tied 0 without the macro)
module serial_request_scheduler #(
  parameter int         NUM_CONSOLES   = 1,
  parameter logic [7:0] BASE_CHAR      = 8'h41,
  parameter int         TIMEOUT_CYCLES = 500000
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    resp_valid,
  input  logic [7:0]              resp_byte,
  output logic                    resp_ready,
  input  logic [NUM_CONSOLES-1:0] request_frame,
  input  logic [NUM_CONSOLES-1:0] frame_delivered,
  input  logic                    clear_prebuffer,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [7:0]              fifo_data,
  output logic [NUM_CONSOLES-1:0] pending,
  output logic                    prebuffer_done,
  output logic                    timeout_err
);

  localparam int NC = NUM_CONSOLES;
  localparam int PW = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_GAP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d, grant_idx, hi_idx, lo_idx;
  logic [NC-1:0]   pending_q, pending_d, eligible, lock_set, lock_tmo;
  logic            prebuf_q;
  logic            wr_en_q;
  logic [7:0]      data_q;
  logic            take_resp, take_req, any_elig, hi_found, lo_found;

  // A grant in the same cycle as clear_prebuffer would leave a request outstanding
  // with no lock recorded, so clear_prebuffer also blocks eligibility.
  assign eligible = {NC{prebuf_q & ~clear_prebuffer}} & request_frame
                    & ~pending_q & ~frame_delivered;

  // Round-robin: lowest eligible index at or above the pointer, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NC; i++) begin
      if (eligible[i] && !hi_found && (PW'(i) >= rr_ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = PW'(i);
      end
      if (eligible[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = PW'(i);
      end
    end
    any_elig  = lo_found;
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  // FSM next state; the two-cycle WRITE/GAP tail lets fifo_full settle before the next decision.
  always_comb begin
    state_d   = state_q;
    take_resp = 1'b0;
    take_req  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_full) begin
          if (resp_valid) begin
            take_resp = 1'b1;
            state_d   = ST_WRITE;
          end else if (any_elig) begin
            take_req = 1'b1;
            state_d  = ST_WRITE;
          end
        end
      end
      ST_WRITE: state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lock_set = '0;
    for (int i = 0; i < NC; i++) begin
      lock_set[i] = take_req && (grant_idx == PW'(i));
    end
  end

  // Pointer wraps NC-1 -> 0; with one console it is always 0.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (clear_prebuffer) begin
      rr_ptr_d = '0;
    end else if (take_req) begin
      rr_ptr_d = (grant_idx == PW'(NC - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Set and delivery never coincide for one console: delivery blocks eligibility.
  always_comb begin
    if (clear_prebuffer) begin
      pending_d = '0;
    end else begin
      pending_d = (pending_q | lock_set) & ~frame_delivered & ~lock_tmo;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      pending_q <= '0;
      prebuf_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      wr_en_q   <= take_resp | take_req;
      if (take_resp) begin
        data_q <= resp_byte;
      end else if (take_req) begin
        data_q <= BASE_CHAR + 8'(grant_idx);
      end
      if (clear_prebuffer) begin
        prebuf_q <= 1'b0;
      end else if (request_frame == '0) begin
        prebuf_q <= 1'b1;
      end
    end
  end

`ifdef REQ_TIMEOUT_EN
  logic [19:0] tmo_cnt_q [NC];
  logic        tmo_err_q;

  // Counter sits at 0 while unlocked, so it restarts from 0 on every lock set.
  always_comb begin
    lock_tmo = '0;
    for (int i = 0; i < NC; i++) begin
      lock_tmo[i] = pending_q[i] && (tmo_cnt_q[i] == 20'(TIMEOUT_CYCLES - 1))
                    && !frame_delivered[i] && !clear_prebuffer;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      tmo_err_q <= 1'b0;
      for (int i = 0; i < NC; i++) begin
        tmo_cnt_q[i] <= '0;
      end
    end else begin
      tmo_err_q <= |lock_tmo;
      for (int i = 0; i < NC; i++) begin
        if (!pending_q[i] || lock_tmo[i] || frame_delivered[i] || clear_prebuffer) begin
          tmo_cnt_q[i] <= '0;
        end else begin
          tmo_cnt_q[i] <= tmo_cnt_q[i] + 20'd1;
        end
      end
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign lock_tmo    = '0;
  assign timeout_err = 1'b0;
`endif

  // resp_ready is combinational: high in the cycle whose closing edge takes resp_byte.
  assign resp_ready     = take_resp;
  assign fifo_wr_en     = wr_en_q;
  assign fifo_data      = data_q;
  assign pending        = pending_q;
  assign prebuffer_done = prebuf_q;

endmodule

// File: tb/tb_serial_request_scheduler.sv
// Purpose : directed self-checking bench for serial_request_scheduler (2 consoles).
// Latency : inputs driven 1 time unit after each rising edge, outputs logged on falling edges.
// Backpressure: fifo_full driven directly by the bench; no FIFO model is attached.
module tb_serial_request_scheduler;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       resp_valid;
  logic [7:0] resp_byte;
  logic       resp_ready;
  logic [1:0] request_frame;
  logic [1:0] frame_delivered;
  logic       clear_prebuffer;
  logic       fifo_full;
  logic       fifo_wr_en;
  logic [7:0] fifo_data;
  logic [1:0] pending;
  logic       prebuffer_done;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_cnt = 0;
  int to_cnt = 0;
  int to_cyc = -1;
  int wd[$];
  int wc[$];
  int c;

  serial_request_scheduler #(
    .NUM_CONSOLES  (2),
    .BASE_CHAR     (8'h41),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .resp_valid     (resp_valid),
    .resp_byte      (resp_byte),
    .resp_ready     (resp_ready),
    .request_frame  (request_frame),
    .frame_delivered(frame_delivered),
    .clear_prebuffer(clear_prebuffer),
    .fifo_full      (fifo_full),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_data      (fifo_data),
    .pending        (pending),
    .prebuffer_done (prebuffer_done),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/handshake log, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_l) begin
      if (fifo_wr_en) begin
        wd.push_back(int'(fifo_data));
        wc.push_back(cyc);
      end
      if (resp_ready) rdy_cnt <= rdy_cnt + 1;
      if (timeout_err) begin
        to_cnt <= to_cnt + 1;
        to_cyc <= cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int log_byte(input int i);
    return (i < wd.size()) ? wd[i] : -1;
  endfunction

  function automatic int log_cyc(input int i);
    return (i < wc.size()) ? wc[i] : -1;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for resp_ready with resp_valid already high, then drops resp_valid after the edge.
  task automatic wait_take();
    bit taken = 1'b0;
    for (int k = 0; k < 50 && !taken; k++) begin
      @(negedge clk);
      if (resp_ready) taken = 1'b1;
    end
    check("resp_taken", int'(taken), 1);
    @(posedge clk);
    #1;
    resp_valid = 1'b0;
  endtask

  task automatic send_resp(input logic [7:0] b);
    resp_byte  = b;
    resp_valid = 1'b1;
    wait_take();
  endtask

  initial begin
    rst_l           = 1'b0;
    resp_valid      = 1'b0;
    resp_byte       = 8'h00;
    request_frame   = 2'b00;
    frame_delivered = 2'b00;
    clear_prebuffer = 1'b0;
    fifo_full       = 1'b0;
    step(3);
    check("rst_wr_en",   int'(fifo_wr_en), 0);
    check("rst_data",    int'(fifo_data), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_prebuf",  int'(prebuffer_done), 0);
    check("rst_ready",   int'(resp_ready), 0);
    check("rst_tmo",     int'(timeout_err), 0);
    rst_l = 1'b1;

    // 1: prebuffer arms on all-low, then both consoles requested in RR order.
    step(1);
    check("t1_prebuf", int'(prebuffer_done), 1);
    wd.delete(); wc.delete();
    request_frame = 2'b11;
    step(12);
    check("t1_count",   wd.size(), 2);
    check("t1_byte0",   log_byte(0), 8'h41);
    check("t1_byte1",   log_byte(1), 8'h42);
    check("t1_spacing", log_cyc(1) - log_cyc(0), 3);
    check("t1_pending", int'(pending), 2'b11);
    check("t1_hold",    int'(fifo_data), 8'h42);

    // 4: delivery releases lock 0; re-issue only after the pulse cycle.
    wd.delete(); wc.delete();
    c = cyc;
    frame_delivered = 2'b01;
    step(1);
    frame_delivered = 2'b00;
    check("t4_pend_clr", int'(pending), 2'b10);
    step(6);
    check("t4_count",   wd.size(), 1);
    check("t4_byte",    log_byte(0), 8'h41);
    check("t4_cycle",   log_cyc(0), c + 2);
    check("t4_pending", int'(pending), 2'b11);

    // 2: response beats an eligible console in the same cycle.
    wd.delete(); wc.delete();
    rdy_cnt = 0;
    c = cyc;
    frame_delivered = 2'b01;
    step(1);
    frame_delivered = 2'b00;
    send_resp(8'h55);
    step(8);
    check("t2_count",  wd.size(), 2);
    check("t2_resp",   log_byte(0), 8'h55);
    check("t2_lat",    log_cyc(0), c + 2);
    check("t2_req",    log_byte(1), 8'h41);
    check("t2_req_at", log_cyc(1), c + 5);
    check("t2_ready",  rdy_cnt, 1);

    // 3: fifo_full stalls a waiting response.
    wd.delete(); wc.delete();
    rdy_cnt    = 0;
    fifo_full  = 1'b1;
    resp_byte  = 8'h66;
    resp_valid = 1'b1;
    step(10);
    check("t3_no_write", wd.size(), 0);
    check("t3_no_ready", rdy_cnt, 0);
    fifo_full = 1'b0;
    c = cyc;
    wait_take();
    step(4);
    check("t3_count", wd.size(), 1);
    check("t3_byte",  log_byte(0), 8'h66);
    check("t3_cycle", log_cyc(0), c + 1);
    check("t3_ready", rdy_cnt, 1);

    // 5: clear_prebuffer during GAP of an in-flight response.
    wd.delete(); wc.delete();
    send_resp(8'h77);
    step(1);
    clear_prebuffer = 1'b1;
    step(1);
    clear_prebuffer = 1'b0;
    check("t5_pending", int'(pending), 2'b00);
    check("t5_prebuf",  int'(prebuffer_done), 0);
    step(10);
    check("t5_inflight", wd.size(), 1);
    check("t5_byte",     log_byte(0), 8'h77);
    request_frame = 2'b00;
    step(1);
    check("t5_rearm", int'(prebuffer_done), 1);
    request_frame = 2'b11;
    step(12);
    check("t5_count", wd.size(), 3);
    check("t5_req0",  log_byte(1), 8'h41);
    check("t5_req1",  log_byte(2), 8'h42);

    // 6: lock timeout (only with the macro); otherwise the lock must persist.
    wd.delete(); wc.delete();
    to_cnt = 0;
    c = cyc;
    frame_delivered = 2'b11;
    request_frame   = 2'b01;
    step(1);
    frame_delivered = 2'b00;
    step(100);
    check("t6_held", int'(pending[0]), 1);
    step(1);
`ifdef REQ_TIMEOUT_EN
    check("t6_released", int'(pending[0]), 0);
    step(5);
    check("t6_tmo_pulses", to_cnt, 1);
    check("t6_tmo_cycle",  to_cyc, c + 102);
    check("t6_count",      wd.size(), 2);
    check("t6_reissue",    log_byte(1), 8'h41);
    check("t6_reissue_at", log_cyc(1), c + 103);
`else
    check("t6_still_held", int'(pending[0]), 1);
    step(5);
    check("t6_no_tmo", to_cnt, 0);
    check("t6_count",  wd.size(), 1);
`endif

    // Reset during WRITE discards the byte.
    request_frame = 2'b00;
    step(2);
    wd.delete(); wc.delete();
    send_resp(8'h88);
    check("rw_wr_en", int'(fifo_wr_en), 1);
    rst_l = 1'b0;
    #1;
    check("rw_wr_cut",   int'(fifo_wr_en), 0);
    check("rw_data_clr", int'(fifo_data), 0);
    check("rw_pending",  int'(pending), 0);
    step(2);
    rst_l = 1'b1;
    step(6);
    check("rw_no_write", wd.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
